// File: rtl/bin2bcd_if.sv
// bin2bcd_if: conversion request/result bundle between a requester and bin2bcd_conv
interface bin2bcd_if;
   logic        start;
   logic [26:0] bin_in;
   logic [31:0] bcd_out;
   logic        busy;
   logic        done;
   logic        ovf;
   modport master (output start, bin_in, input bcd_out, busy, done, ovf);
   modport slave  (input start, bin_in, output bcd_out, busy, done, ovf);
endinterface

// File: rtl/bin2bcd_conv.sv
// bin2bcd_conv: 27-bit binary to 8-digit BCD via shift-add-3; BIN2BCD_SATURATE_EN clamps overflow to 99999999
module bin2bcd_conv (
   input  logic      clk,
   input  logic      rst,
   bin2bcd_if.slave  bus
);
   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
   state_t      state_q, state_d;
   logic [26:0] sr_q, sr_d;
   logic [35:0] acc_q, acc_d, adj;
   logic [4:0]  cnt_q, cnt_d;
   logic [31:0] bcd_q, bcd_d;
   logic        ovf_q, ovf_d;
   // add 3 to every nibble >= 5 so the following shift carries correctly into the next digit
   always_comb begin
      adj = acc_q;
      for (int i = 0; i < 9; i++)
         adj[4*i +: 4] = acc_q[4*i +: 4] >= 4'd5 ? acc_q[4*i +: 4] + 4'd3 : acc_q[4*i +: 4];
   end
   // next-state, datapath and result capture; result is taken from the post-shift accumulator on the last step
   always_comb begin
      state_d = state_q;
      sr_d    = sr_q;
      acc_d   = acc_q;
      cnt_d   = cnt_q;
      bcd_d   = bcd_q;
      ovf_d   = ovf_q;
      case (state_q)
         SHIFT: begin
            {acc_d, sr_d} = {adj, sr_q} << 1;
            cnt_d = cnt_q - 5'd1;
            if (cnt_q == 5'd1) begin
               state_d = DONE;
               ovf_d   = |acc_d[35:32];
`ifdef BIN2BCD_SATURATE_EN
               bcd_d   = ovf_d ? 32'h99999999 : acc_d[31:0];
`else
               bcd_d   = acc_d[31:0];
`endif
            end
         end
         default: begin
            state_d = bus.start ? SHIFT : IDLE;
            if (bus.start) begin
               sr_d  = bus.bin_in;
               acc_d = '0;
               cnt_d = 5'd27;
            end
         end
      endcase
   end
   // state register with synchronous reset that aborts any conversion
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         sr_q    <= '0;
         acc_q   <= '0;
         cnt_q   <= '0;
         bcd_q   <= '0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         sr_q    <= sr_d;
         acc_q   <= acc_d;
         cnt_q   <= cnt_d;
         bcd_q   <= bcd_d;
         ovf_q   <= ovf_d;
      end
   end
   assign bus.busy    = state_q == SHIFT;
   assign bus.done    = state_q == DONE;
   assign bus.bcd_out = bcd_q;
   assign bus.ovf     = ovf_q;
endmodule

// File: doc/bin2bcd_conv.md
BIN2BCD_CONV -- requirements
Module: bin2bcd_conv

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-high reset: clk and rst, with rst sampled only on the rising edge of clk.
REQ-002 The block SHALL have the following ports:
- clk  input  1  system clock; all state updates on its rising edge
- rst  input  1  synchronous active-high reset
- start  input  1  conversion request; sampled on each rising edge of clk
- bin_in  input  27  unsigned binary value; captured when start is accepted
- bcd_out  output  32  8 packed BCD digits; [31:28] is the most significant digit, [3:0] the least; drives the seven-segment display data input
- busy  output  1  high while a conversion is in progress
- done  output  1  one-cycle pulse when bcd_out updates
- ovf  output  1  high when the last captured bin_in exceeded 99,999,999

Function
REQ-003 The block SHALL implement a three-state FSM with states IDLE, SHIFT and DONE.
REQ-004 In IDLE or DONE, start=1 at edge N SHALL capture bin_in into a 27-bit shift register, clear a 36-bit BCD accumulator, load iteration count 27, and enter SHIFT.
REQ-005 In SHIFT, each edge SHALL first add 3 to every accumulator nibble that is >= 5, then shift {accumulator, shift register} left by 1 bit, then decrement the count.
REQ-006 At edge N+27 the count SHALL reach 0 and the FSM SHALL enter DONE; at that same edge bcd_out and ovf SHALL be updated.
REQ-007 done SHALL be 1 only during the DONE cycle (edges N+27 to N+28), giving a latency of 27 cycles from start acceptance to done.
REQ-008 DONE SHALL last exactly one cycle; the FSM SHALL then return to IDLE, or re-enter SHIFT if start=1 in that cycle, which allows back-to-back conversions every 28 cycles.
REQ-009 busy SHALL equal 1 exactly while the FSM is in SHIFT.
REQ-010 start=1 while in SHIFT SHALL be ignored; bin_in changes during SHIFT SHALL NOT affect the result.
REQ-011 bcd_out and ovf SHALL hold their values between done pulses.
REQ-012 ovf SHALL be 1 when the 9th BCD digit (accumulator [35:32]) is nonzero at completion, and 0 otherwise.
REQ-013 For inputs <= 99,999,999, bcd_out SHALL equal the exact 8-digit BCD value, with every nibble in 0..9.

Reset
REQ-014 rst=1 SHALL force, at the next edge: FSM=IDLE, bcd_out=32'h00000000, busy=0, done=0, ovf=0, count=0, accumulator=0.
REQ-015 rst SHALL take priority over start and over any in-progress conversion.
REQ-016 rst asserted mid-SHIFT SHALL abort the conversion, produce no done pulse and leave bcd_out=0.

Configuration
REQ-017 With macro BIN2BCD_SATURATE_EN defined, an overflowing conversion SHALL set bcd_out=32'h99999999 and ovf=1.
REQ-018 Without BIN2BCD_SATURATE_EN, an overflowing conversion SHALL set bcd_out to the low 8 digits (accumulator [31:0], i.e. value mod 10^8) and ovf=1.
REQ-019 Non-overflow behaviour and timing SHALL be identical in both builds.

Verification
REQ-020 bin_in=0, start pulse -> done at acceptance+27 cycles, bcd_out=32'h00000000, ovf=0, busy high for exactly 27 cycles.
REQ-021 bin_in=12345678 -> bcd_out=32'h12345678, ovf=0; then bin_in=99999999 -> bcd_out=32'h99999999, ovf=0.
REQ-022 bin_in=134217727 -> with BIN2BCD_SATURATE_EN: bcd_out=32'h99999999, ovf=1; without it: bcd_out=32'h34217727, ovf=1.
REQ-023 start=1 held continuously with bin_in incrementing -> done every 28 cycles; each result matches the bin_in captured at acceptance; starts during SHIFT are ignored.
REQ-024 Convert 42 (bcd_out=32'h00000042), then start 55 and assert rst at SHIFT cycle 10 -> no done pulse, bcd_out=0, busy=0; a following start with 7 -> bcd_out=32'h00000007 after 27 cycles.
